// File: rtl/pulse_period_meter_if.sv
// Bundle of measurement control and result signals for pulse_period_meter.
// The consumer (master) drives enable and the pulse stream; the meter (slave)
// returns the measured period, its strobe and the lock/timeout status.
interface pulse_period_meter_if #(
  parameter int WIDTH = 16
);
  logic             enable;
  logic             in_pulse;
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             timeout;

  modport master (
    output enable,
    output in_pulse,
    input  period,
    input  period_valid,
    input  locked,
    input  timeout
  );

  modport slave (
    input  enable,
    input  in_pulse,
    output period,
    output period_valid,
    output locked,
    output timeout
  );
endinterface

// File: rtl/pulse_period_meter.sv
// Measures the number of clk cycles between successive rising edges of
// in_pulse. Each completed measurement is reported with a one-cycle strobe;
// lock tracks agreement between consecutive periods and a sticky timeout
// flags a pulse stream that has stopped.
module pulse_period_meter #(
  parameter int WIDTH     = 16,
  parameter int MAX_COUNT = 65535,
  parameter int TOLERANCE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pulse_period_meter_if.slave  bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MEAS = 1'b1;

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH:0]   TOL_EXT = (WIDTH+1)'(TOLERANCE);

  logic [0:0]       state;
  logic [WIDTH-1:0] count;
  logic             prev_in;
  logic             has_prev;
  logic [WIDTH-1:0] period_q;
  logic             period_valid_q;
  logic             locked_q;
  logic             timeout_q;
  logic             rise;
  logic [WIDTH:0]   diff;

  assign rise = bus.in_pulse & ~prev_in;

  // Magnitude of the difference between the running count and the last
  // reported period, one bit wider so the subtraction can never wrap.
  always_comb begin
    diff = '0;
    if (count >= period_q) begin
      diff = {1'b0, count} - {1'b0, period_q};
    end else begin
      diff = {1'b0, period_q} - {1'b0, count};
    end
  end

  // Edge tracking, period counter, lock and timeout state machine.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      count          <= '0;
      prev_in        <= 1'b0;
      has_prev       <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      prev_in        <= bus.in_pulse;
      period_valid_q <= 1'b0;
      if (!bus.enable) begin
        state    <= IDLE;
        count    <= '0;
        locked_q <= 1'b0;
        has_prev <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            count    <= '0;
            has_prev <= 1'b0;
            if (rise) begin
              state <= MEAS;
              count <= WIDTH'(1);
            end
          end
          MEAS: begin
            if (rise) begin
              period_q       <= count;
              period_valid_q <= 1'b1;
              count          <= WIDTH'(1);
              timeout_q      <= 1'b0;
              locked_q       <= has_prev && (diff <= TOL_EXT);
              has_prev       <= 1'b1;
            end else if (count == MAX_CNT) begin
              timeout_q <= 1'b1;
              locked_q  <= 1'b0;
              has_prev  <= 1'b0;
              state     <= IDLE;
              count     <= '0;
            end else begin
              count <= count + WIDTH'(1);
            end
          end
          default: begin
            state <= IDLE;
            count <= '0;
          end
        endcase
      end
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = period_valid_q;
  assign bus.locked       = locked_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter. Two instances share one stimulus:
// dut_a (MAX_COUNT=1200, TOLERANCE=0) and dut_b (MAX_COUNT=50, TOLERANCE=2),
// so strict lock, tolerant lock and the timeout path are covered together.
module tb_pulse_period_meter;

  logic clk;
  logic rst_n;
  logic enable;
  logic in_pulse;

  int total;
  int bad;

  pulse_period_meter_if #(.WIDTH(16)) bus_a ();
  pulse_period_meter_if #(.WIDTH(16)) bus_b ();

  assign bus_a.enable   = enable;
  assign bus_a.in_pulse = in_pulse;
  assign bus_b.enable   = enable;
  assign bus_b.in_pulse = in_pulse;

  pulse_period_meter #(.WIDTH(16), .MAX_COUNT(1200), .TOLERANCE(0)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  pulse_period_meter #(.WIDTH(16), .MAX_COUNT(50), .TOLERANCE(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit reset_before;
    int spacing;
    int width;
    bit exp_valid;
    int exp_period;
    bit exp_lock_a;
    bit check_b;
    bit exp_lock_b;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseOnce();
    in_pulse = 1'b1;
    step(1);
    in_pulse = 1'b0;
  endtask

  task automatic doReset();
    rst_n    = 1'b0;
    enable   = 1'b1;
    in_pulse = 1'b0;
    step(2);
    checkOutput("rst_period_a", int'(bus_a.period), 0);
    checkOutput("rst_valid_a", int'(bus_a.period_valid), 0);
    checkOutput("rst_locked_a", int'(bus_a.locked), 0);
    checkOutput("rst_timeout_a", int'(bus_a.timeout), 0);
    checkOutput("rst_timeout_b", int'(bus_b.timeout), 0);
    rst_n = 1'b1;
    step(1);
  endtask

  // Drive one rising edge, check the strobe that follows it, then hold the
  // rest of the spacing and confirm no further strobe appears in the window.
  task automatic applyStimulus(input vec_t v);
    int extra;
    extra = 0;
    if (v.reset_before) doReset();
    for (int i = 0; i < v.spacing; i++) begin
      in_pulse = (i < v.width);
      step(1);
      if (i == 0) begin
        checkOutput("vec_valid_a", int'(bus_a.period_valid), int'(v.exp_valid));
        if (v.exp_valid) checkOutput("vec_period_a", int'(bus_a.period), v.exp_period);
        checkOutput("vec_locked_a", int'(bus_a.locked), int'(v.exp_lock_a));
        checkOutput("vec_timeout_a", int'(bus_a.timeout), 0);
        if (v.check_b) begin
          checkOutput("vec_valid_b", int'(bus_b.period_valid), int'(v.exp_valid));
          if (v.exp_valid) checkOutput("vec_period_b", int'(bus_b.period), v.exp_period);
          checkOutput("vec_locked_b", int'(bus_b.locked), int'(v.exp_lock_b));
        end
      end else begin
        if (bus_a.period_valid) extra++;
        if (v.check_b && bus_b.period_valid) extra++;
      end
    end
    checkOutput("vec_extra_strobes", extra, 0);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    enable   = 1'b0;
    in_pulse = 1'b0;

    // Divider ticks every 1000 cycles (dut_b times out here and is not checked)
    vecs.push_back('{1'b1, 1000, 1, 1'b0, 0,    1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1000, 1, 1'b1, 1000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1000, 1, 1'b1, 1000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1000, 1, 1'b1, 1000, 1'b1, 1'b0, 1'b0});
    // Spacings 10,10,12,12: strict vs tolerance-2 lock
    vecs.push_back('{1'b1, 10, 1, 1'b0, 0,  1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 10, 1, 1'b1, 10, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 12, 1, 1'b1, 10, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 12, 1, 1'b1, 12, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 12, 1, 1'b1, 12, 1'b1, 1'b1, 1'b1});
    // Wide pulses: high for 5 cycles, rises 20 apart
    vecs.push_back('{1'b1, 20, 5, 1'b0, 0,  1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 20, 5, 1'b1, 20, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 20, 5, 1'b1, 20, 1'b1, 1'b1, 1'b1});
    // Minimum period of 2
    vecs.push_back('{1'b1, 2, 1, 1'b0, 0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 2, 1, 1'b1, 2, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 2, 1, 1'b1, 2, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 2, 1, 1'b1, 2, 1'b1, 1'b1, 1'b1});

    $display("[TB] running %0d table vectors", vecs.size());
    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Timeout on dut_b after a locked 30-cycle stream, then recovery
    doReset();
    pulseOnce();
    step(29);
    pulseOnce();
    checkOutput("to_first_period_b", int'(bus_b.period), 30);
    step(29);
    pulseOnce();
    checkOutput("to_locked_before_b", int'(bus_b.locked), 1);
    step(49);
    checkOutput("to_not_yet_b", int'(bus_b.timeout), 0);
    step(1);
    checkOutput("to_timeout_b", int'(bus_b.timeout), 1);
    checkOutput("to_locked_b", int'(bus_b.locked), 0);
    checkOutput("to_period_held_b", int'(bus_b.period), 30);
    pulseOnce();
    checkOutput("to_restart_valid_b", int'(bus_b.period_valid), 0);
    checkOutput("to_still_timeout_b", int'(bus_b.timeout), 1);
    step(29);
    pulseOnce();
    checkOutput("to_recover_valid_b", int'(bus_b.period_valid), 1);
    checkOutput("to_recover_period_b", int'(bus_b.period), 30);
    checkOutput("to_recover_timeout_b", int'(bus_b.timeout), 0);
    checkOutput("to_recover_locked_b", int'(bus_b.locked), 0);

    // Rise coincident with count == MAX_COUNT on dut_b
    doReset();
    pulseOnce();
    step(49);
    pulseOnce();
    checkOutput("max_valid_b", int'(bus_b.period_valid), 1);
    checkOutput("max_period_b", int'(bus_b.period), 50);
    checkOutput("max_timeout_b", int'(bus_b.timeout), 0);

    // Enable dropped mid-measurement with in_pulse high on dut_a
    doReset();
    pulseOnce();
    step(99);
    pulseOnce();
    checkOutput("en_first_period_a", int'(bus_a.period), 100);
    step(99);
    pulseOnce();
    checkOutput("en_locked_a", int'(bus_a.locked), 1);
    step(39);
    in_pulse = 1'b1;
    enable   = 1'b0;
    step(1);
    checkOutput("en_drop_valid_a", int'(bus_a.period_valid), 0);
    checkOutput("en_drop_locked_a", int'(bus_a.locked), 0);
    checkOutput("en_drop_period_a", int'(bus_a.period), 100);
    enable = 1'b1;
    step(3);
    checkOutput("en_reenable_valid_a", int'(bus_a.period_valid), 0);
    in_pulse = 1'b0;
    step(5);
    pulseOnce();
    checkOutput("en_no_spurious_a", int'(bus_a.period_valid), 0);
    step(99);
    pulseOnce();
    checkOutput("en_after_valid_a", int'(bus_a.period_valid), 1);
    checkOutput("en_after_period_a", int'(bus_a.period), 100);
    checkOutput("en_after_locked_a", int'(bus_a.locked), 0);

    // Reset pulsed mid-count while locked
    step(99);
    pulseOnce();
    checkOutput("rm_locked_a", int'(bus_a.locked), 1);
    step(39);
    rst_n = 1'b0;
    step(1);
    checkOutput("rm_period_a", int'(bus_a.period), 0);
    checkOutput("rm_valid_a", int'(bus_a.period_valid), 0);
    checkOutput("rm_locked_a_clr", int'(bus_a.locked), 0);
    checkOutput("rm_timeout_a", int'(bus_a.timeout), 0);
    checkOutput("rm_timeout_b", int'(bus_b.timeout), 0);
    rst_n = 1'b1;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_period_meter.md
Name: pulse_period_meter

Overview:
- Receive-side companion to the team's clock-divider tick generators: measures the number of clk cycles between successive rising edges of an incoming pulse stream.
- Reports each measured period with a one-cycle valid strobe, flags lock when consecutive periods agree, and flags timeout when pulses stop.
- Used to check divider outputs on-chip and to derive rate status for downstream display logic.

Parameters:
- WIDTH, 16, width of the period counter and period output.
- MAX_COUNT, 65535, count value at which a measurement is abandoned as a timeout; must be ≤ 2^WIDTH-1 and ≥ 2.
- TOLERANCE, 0, maximum absolute difference between consecutive periods that still counts as a match for lock.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous reset, active-low.
- enable  input  1  measurement enable; low forces IDLE.
- in_pulse  input  1  pulse stream under measurement, synchronous to clk, any high width.
- period  output  WIDTH  last completed period in clk cycles.
- period_valid  output  1  one-cycle strobe; period updated this cycle.
- locked  output  1  high while consecutive periods match within TOLERANCE.
- timeout  output  1  sticky flag; no edge arrived within MAX_COUNT cycles.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, count=0, prev_in=0, period=0, period_valid=0, locked=0, timeout=0.
- Edge detect:
  - prev_in <= in_pulse every cycle, including while enable=0.
  - rise = in_pulse & ~prev_in. Only rising edges are counted; high width is irrelevant.
- IDLE state:
  - count held at 0.
  - On rise with enable=1: go to MEAS, count <= 1.
  - No period reported for the first edge.
- MEAS state, no rise:
  - count < MAX_COUNT: count <= count+1.
  - count == MAX_COUNT: timeout <= 1, locked <= 0, state <= IDLE, count <= 0. period is unchanged and no strobe is issued.
- MEAS state, rise:
  - period <= count and period_valid <= 1 on the same posedge.
  - count <= 1; remain in MEAS.
  - timeout <= 0 (cleared by any completed measurement).
- Period definition:
  - Rise in cycle t0 and next rise in cycle t0+N give period=N.
  - Strobe is visible in cycle t0+N+1, i.e. one cycle after in_pulse is first sampled high.
- period_valid is high for exactly one cycle per completed measurement. Back-to-back strobes are impossible because the minimum period is 2.
- Lock:
  - On each completed measurement, compare the new count with the previously reported period: locked <= (|count - period| ≤ TOLERANCE).
  - The first measurement after IDLE never sets lock; a has_prev bit, cleared on IDLE entry, gates the compare.
  - locked is cleared on mismatch, timeout, enable=0, and reset.
- enable=0:
  - Next posedge: state=IDLE, count=0, locked=0, period_valid=0.
  - period and timeout hold their values.
  - Re-enabling with in_pulse already high does not produce a spurious edge, because prev_in keeps tracking.
- Simultaneous events:
  - rst_n=0 overrides everything.
  - enable=0 overrides a rise.
  - A rise in the same cycle count==MAX_COUNT is a valid measurement of MAX_COUNT; it is not a timeout.
- Arithmetic:
  - The counter saturates by construction and never wraps.
  - Difference is computed WIDTH+1 bits wide, unsigned magnitude.

Test Plan:
- Reset, enable=1, single-cycle pulses every 1000 cycles (divider with max_value 999):
  - First pulse produces no strobe.
  - Then period=1000 with one-cycle period_valid, one cycle after each pulse.
  - locked=1 from the second strobe onward; timeout=0.
- Pulses with spacings 10, 10, 12, 12 (TOLERANCE=0):
  - period=10 (locked 0), 10 (locked 1), 12 (locked 0), 12 (locked 1).
  - Rerun with TOLERANCE=2: locked stays 1 across the 10→12 step.
- in_pulse held high for 5 cycles, rising edges 20 cycles apart: period=20 (high width ignored).
- MAX_COUNT=50, one pulse then silence:
  - timeout=1 in the cycle after count reaches 50.
  - locked=0 and period unchanged.
  - Next two pulses 30 apart: period=30 and timeout cleared.
- Mid-measurement tests with 100-cycle pulses:
  - Drop enable at count=40 with in_pulse high: state IDLE, locked=0, no strobe. Raise enable while in_pulse is still high: no edge is seen. The following two rises 100 apart give period=100.
  - Pulse rst_n low mid-count: all outputs 0 on the next cycle.
- Pulses exactly 2 cycles apart (minimum): period=2 on each strobe, strobes separated by one idle cycle. A rise coincident with count==MAX_COUNT reports period=MAX_COUNT with no timeout.
